lock_ctrl: RTL
==============

Name: lock_ctrl

Overview:
Top-level sequencer for the digital door lock. It decodes keypad events, assembles the 4-digit BCD entry on display, compares it against the stored master and one-time passwords, and drives correct, star, hash and pw_temp_reset into the password-store block. It also owns the door-open timer, the failed-attempt counter and the lockout timer.

Parameters:
OPEN_CYCLES, 50, cycles door_open/correct stay high after a successful match
LOCK_CYCLES, 100, cycles keypad is ignored after MAX_FAIL consecutive failures
MAX_FAIL, 3, consecutive failed checks that trigger lockout (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
key_valid  in  1  one-cycle keypad event strobe
key_code  in  4  0-9 digit, 4'hA star, 4'hB hash, 4'hC-F ignored
pw  in  16  stored master password (4 BCD digits)
pw_temp  in  16  stored one-time password
pw_temp_valid  in  1  pw_temp holds a usable password
display  out  16  current entry, newest digit in [3:0]
star  out  1  registered star pulse to password store
hash  out  1  registered hash pulse to password store
correct  out  1  high in OPEN only
pw_temp_reset  out  1  one-cycle pulse, invalidates one-time password
door_open  out  1  door actuator
lockout  out  1  high in LOCKED
fail_cnt  out  2  consecutive failures (status)

Behaviour:
- Reset is active-low and synchronous, sampled on the rising clk edge. While low: state IDLE, all outputs 0, all counters and key register cleared.
- Key stage: key_valid/key_code are registered once (key_r). star/hash outputs = key_r decode, so they lag the input by 1 cycle. All state decisions use key_r. Codes C-F produce nothing.
- Digit shift: display <= {display[11:0], digit}; digit_cnt increments and saturates at 4. Digits arriving when digit_cnt==4 are ignored.
- IDLE: digit -> shift, cnt=1, go ENTRY. star/hash ignored.
- ENTRY: digit -> shift. star -> clear display and cnt, go IDLE (cancel). hash with cnt==4 -> CHECK. hash with cnt<4 -> FAIL.
- CHECK (1 cycle, keys ignored):
  - m_pw = (display==pw); m_tmp = pw_temp_valid && (display==pw_temp).
  - m_pw -> OPEN.
  - m_tmp && !m_pw -> pw_temp_reset=1 this cycle, then OPEN.
  - Any match clears fail_cnt and loads the timer with OPEN_CYCLES.
  - No match -> FAIL.
- FAIL (1 cycle): fail_cnt+1. If it reaches MAX_FAIL, go LOCKED and load timer with LOCK_CYCLES; else go IDLE. Display and cnt cleared.
- OPEN: correct=1, door_open=1, timer decrements.
  - Timer reaching 0 -> IDLE, display cleared. Total OPEN dwell = OPEN_CYCLES.
  - star -> CFG_PW; hash -> CFG_TMP. Either clears display and cnt and takes priority over timeout in the same cycle. The password store sees correct && star/hash on this same edge.
  - Digits ignored.
- CFG_PW / CFG_TMP: correct=0, door_open=0, digits shift as in ENTRY.
  - Terminating key (star for CFG_PW, hash for CFG_TMP) -> IDLE. Display is held unchanged on that cycle so the store latches it, then cleared on the following cycle. Exit happens regardless of cnt.
  - The other terminator is ignored.
- LOCKED: lockout=1, every key ignored and star/hash outputs suppressed. At timeout: fail_cnt=0, go IDLE.
- star/hash outputs are suppressed in IDLE, ENTRY, FAIL and CHECK as well. They are only forwarded in OPEN and the CFG states, so the store cannot be steered outside a correct session.
- Reset asserted in any state (including mid-CFG or mid-lockout) returns to IDLE next edge with all counters cleared.

Decomposition:
- Package lock_pkg:
  - state enum: IDLE, ENTRY, CHECK, FAIL, OPEN, CFG_PW, CFG_TMP, LOCKED
  - KEY_STAR=4'hA, KEY_HASH=4'hB, NUM_DIGITS=4
  - timer width = clog2(max(OPEN_CYCLES, LOCK_CYCLES)+1)
- Sub-module lock_timer: load value, decrement, done flag. One instance, shared by OPEN and LOCKED.

Test Plan (OPEN_CYCLES=8, LOCK_CYCLES=16, MAX_FAIL=3, pw=16'h1234):
- Keys 1,2,3,4,hash -> one cycle CHECK, then correct=door_open=1 for exactly 8 cycles, fail_cnt=0.
- pw_temp=16'h5678, valid=1; enter 5,6,7,8,hash -> pw_temp_reset high exactly 1 cycle in CHECK, then OPEN.
- Three entries of 9,9,9,9,hash -> fail_cnt 1,2, then lockout=1 for 16 cycles. A key during lockout gives no display change and no star/hash pulse. Afterwards fail_cnt=0, state IDLE.
- In OPEN press star, 4,3,2,1, star -> star pulse while correct=1, display=16'h4321 held on the terminating star cycle, then cleared, state IDLE.
- Entry 1,2, star -> display=0, IDLE, no star output. Entry 1,2, hash -> FAIL, fail_cnt=1.
- Reset low mid-CFG_TMP and mid-LOCKED -> next edge: all outputs 0, IDLE. Codes C-F at any time -> no effect.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and constants for the door-lock sequencer.
package lock_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StEntry,
      StCheck,
      StFail,
      StOpen,
      StCfgPw,
      StCfgTmp,
      StLocked
   } state_t;

   localparam logic [3:0]  KEY_STAR   = 4'hA;
   localparam logic [3:0]  KEY_HASH   = 4'hB;
   localparam int unsigned NUM_DIGITS = 4;

   // Bits needed to hold the larger of the two dwell counts.
   function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Down-counting dwell timer shared by the OPEN and LOCKED phases.
module lock_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_cnt;

   // Load takes priority; decrement stops at zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - ONE;
      end
   end

   // Done on the last cycle of the dwell, so a load of N gives N cycles.
   assign o_done = (r_cnt <= ONE);

endmodule

// File: rtl/lock_ctrl.sv
// Door-lock sequencer: keypad decode, entry assembly, password check,
// door-open / lockout timing and password-store handshake.
module lock_ctrl
   import lock_pkg::*;
#(
   parameter int unsigned OPEN_CYCLES = 50,
   parameter int unsigned LOCK_CYCLES = 100,
   parameter int unsigned MAX_FAIL    = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic [15:0] pw,
   input  logic [15:0] pw_temp,
   input  logic        pw_temp_valid,
   output logic [15:0] display,
   output logic        star,
   output logic        hash,
   output logic        correct,
   output logic        pw_temp_reset,
   output logic        door_open,
   output logic        lockout,
   output logic [1:0]  fail_cnt
);

   localparam int unsigned     TW         = timer_width(OPEN_CYCLES, LOCK_CYCLES);
   localparam logic [TW-1:0]   OPEN_LOAD  = TW'(OPEN_CYCLES);
   localparam logic [TW-1:0]   LOCK_LOAD  = TW'(LOCK_CYCLES);
   localparam logic [2:0]      CNT_FULL   = 3'(NUM_DIGITS);
   localparam logic [2:0]      FAIL_LIMIT = 3'(MAX_FAIL);

   logic        r_key_valid;
   logic [3:0]  r_key_code;
   state_t      r_state;
   logic [15:0] r_display;
   logic [2:0]  r_digit_cnt;
   logic [1:0]  r_fail_cnt;

   state_t      w_state_nxt;
   logic [15:0] w_display_nxt;
   logic [2:0]  w_cnt_nxt;
   logic [1:0]  w_fail_nxt;
   logic [2:0]  w_fail_inc;
   logic        w_digit;
   logic        w_shift_ok;
   logic        w_star_key;
   logic        w_hash_key;
   logic        w_fwd;
   logic        w_m_pw;
   logic        w_m_tmp;
   logic        w_tmr_load;
   logic [TW-1:0] w_tmr_val;
   logic        w_tmr_dec;
   logic        w_tmr_done;

   // Register the keypad strobe once; every decision below uses this copy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_key_valid <= 1'b0;
         r_key_code  <= 4'h0;
      end else begin
         r_key_valid <= key_valid;
         r_key_code  <= key_code;
      end
   end

   assign w_digit    = r_key_valid && (r_key_code <= 4'd9);
   assign w_shift_ok = w_digit && (r_digit_cnt < CNT_FULL);
   assign w_star_key = r_key_valid && (r_key_code == KEY_STAR);
   assign w_hash_key = r_key_valid && (r_key_code == KEY_HASH);
   assign w_m_pw     = (r_display == pw);
   assign w_m_tmp    = pw_temp_valid && (r_display == pw_temp);
   assign w_fail_inc = {1'b0, r_fail_cnt} + 3'd1;

   // Store strobes only pass through inside an authenticated session.
   assign w_fwd = (r_state == StOpen) || (r_state == StCfgPw) || (r_state == StCfgTmp);
   assign star  = w_fwd && w_star_key;
   assign hash  = w_fwd && w_hash_key;

   assign display  = r_display;
   assign fail_cnt = r_fail_cnt;

   lock_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_dec      (w_tmr_dec),
      .o_done     (w_tmr_done)
   );

   // Next-state, datapath updates and state-decoded outputs.
   always_comb begin
      w_state_nxt   = r_state;
      w_display_nxt = r_display;
      w_cnt_nxt     = r_digit_cnt;
      w_fail_nxt    = r_fail_cnt;
      w_tmr_load    = 1'b0;
      w_tmr_val     = '0;
      w_tmr_dec     = 1'b0;
      correct       = 1'b0;
      door_open     = 1'b0;
      lockout       = 1'b0;
      pw_temp_reset = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_digit) begin
               w_display_nxt = {r_display[11:0], r_key_code};
               w_cnt_nxt     = 3'd1;
               w_state_nxt   = StEntry;
            end
         end
         StEntry: begin
            if (w_digit) begin
               if (w_shift_ok) begin
                  w_display_nxt = {r_display[11:0], r_key_code};
                  w_cnt_nxt     = r_digit_cnt + 3'd1;
               end
            end else if (w_star_key) begin
               w_display_nxt = 16'h0;
               w_cnt_nxt     = 3'd0;
               w_state_nxt   = StIdle;
            end else if (w_hash_key) begin
               w_state_nxt = (r_digit_cnt == CNT_FULL) ? StCheck : StFail;
            end
         end
         StCheck: begin
            if (w_m_pw || w_m_tmp) begin
               pw_temp_reset = w_m_tmp && !w_m_pw;
               w_fail_nxt    = 2'd0;
               w_tmr_load    = 1'b1;
               w_tmr_val     = OPEN_LOAD;
               w_state_nxt   = StOpen;
            end else begin
               w_state_nxt = StFail;
            end
         end
         StFail: begin
            w_fail_nxt    = w_fail_inc[1:0];
            w_display_nxt = 16'h0;
            w_cnt_nxt     = 3'd0;
            if (w_fail_inc >= FAIL_LIMIT) begin
               w_tmr_load  = 1'b1;
               w_tmr_val   = LOCK_LOAD;
               w_state_nxt = StLocked;
            end else begin
               w_state_nxt = StIdle;
            end
         end
         StOpen: begin
            correct   = 1'b1;
            door_open = 1'b1;
            w_tmr_dec = 1'b1;
            // A configuration request wins over a timeout in the same cycle.
            if (w_star_key || w_hash_key) begin
               w_display_nxt = 16'h0;
               w_cnt_nxt     = 3'd0;
               w_state_nxt   = w_star_key ? StCfgPw : StCfgTmp;
            end else if (w_tmr_done) begin
               w_display_nxt = 16'h0;
               w_cnt_nxt     = 3'd0;
               w_state_nxt   = StIdle;
            end
         end
         StCfgPw, StCfgTmp: begin
            if (w_shift_ok) begin
               w_display_nxt = {r_display[11:0], r_key_code};
               w_cnt_nxt     = r_digit_cnt + 3'd1;
            end else if ((r_state == StCfgPw) ? w_star_key : w_hash_key) begin
               // Display stays valid during the terminator cycle for the store.
               w_display_nxt = 16'h0;
               w_cnt_nxt     = 3'd0;
               w_state_nxt   = StIdle;
            end
         end
         StLocked: begin
            lockout   = 1'b1;
            w_tmr_dec = 1'b1;
            if (w_tmr_done) begin
               w_fail_nxt  = 2'd0;
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= StIdle;
         r_display   <= 16'h0;
         r_digit_cnt <= 3'd0;
         r_fail_cnt  <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_display   <= w_display_nxt;
         r_digit_cnt <= w_cnt_nxt;
         r_fail_cnt  <= w_fail_nxt;
      end
   end

endmodule
